// File: rtl/core_perf_counters_pkg.sv
// core_perf_pkg: shared types and width helpers for the per-core performance
// counter aggregator (core_perf_counters and its perf_counter leaves).
package core_perf_pkg;

    // Run-tracking FSM: wait for work, count, drain idle cycles, then freeze.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } perf_state_t;

    localparam int DEFAULT_RETIRE_WIDTH = 4;
    localparam int DEFAULT_DRAIN_CYCLES = 16;

    // Bits needed to carry 0..retire_width instructions retired in one cycle.
    function automatic int retire_count_width(input int retire_width);
        return $clog2(retire_width + 1);
    endfunction

    // Bits needed to count 0..drain_cycles consecutive idle cycles.
    function automatic int drain_count_width(input int drain_cycles);
        return $clog2(drain_cycles + 1);
    endfunction

    // Drain-counter width for the default build.
    localparam int DRAIN_COUNT_W = drain_count_width(DEFAULT_DRAIN_CYCLES);

endpackage

// File: rtl/core_perf_counters_perf_counter.sv
// perf_counter: one free-running event counter with enable, increment amount,
// freeze and synchronous reset.
// Optional macro PERF_COUNTER_SATURATE_EN: when defined the counter clamps at
// all-ones instead of wrapping modulo 2^WIDTH.
module perf_counter #(
    parameter int WIDTH     = 64,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [INC_WIDTH-1:0] amount,
    input  logic                 freeze,
    output logic [WIDTH-1:0]     count
);

    logic [WIDTH-1:0] count_d;

`ifdef PERF_COUNTER_SATURATE_EN
    localparam int SUM_W = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;
    localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'({WIDTH{1'b1}});

    logic [SUM_W-1:0] sum;

    // Widened sum clamped at all-ones, so a multi-unit step never wraps.
    always_comb begin
        sum     = SUM_W'(count) + SUM_W'(amount);
        count_d = (sum > MAX_VAL) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
`else
    // Plain modulo-2^WIDTH accumulation.
    always_comb begin
        count_d = count + WIDTH'(amount);
    end
`endif

    // Counter register: reset wins, freeze holds, enable accumulates.
    // NOTE: sequential state is written with <= so every flop updates from pre-edge values, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable && !freeze) begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/core_perf_counters.sv
// core_perf_counters: per-core performance-counter aggregator. Samples the
// warp-scheduler event strobes every cycle, accumulates them into core-wide
// and per-warp counters, and raises a sticky `finished` once the core has
// been idle for DRAIN_CYCLES consecutive cycles, freezing every counter.
// Optional macro PERF_COUNTER_SATURATE_EN: counters saturate instead of wrap.
module core_perf_counters
    import core_perf_pkg::*;
#(
    parameter int NUM_WARPS     = 8,
    parameter int COUNTER_WIDTH = 64,
    parameter int RETIRE_WIDTH  = DEFAULT_RETIRE_WIDTH,
    parameter int DRAIN_CYCLES  = DEFAULT_DRAIN_CYCLES
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_WARPS-1:0]                      warp_active,
    input  logic [retire_count_width(RETIRE_WIDTH)-1:0] retire_count,
    input  logic [NUM_WARPS-1:0]                      decode_valid,
    input  logic [NUM_WARPS-1:0]                      eligible_valid,
    input  logic [NUM_WARPS-1:0]                      issue_fire,
    input  logic [NUM_WARPS-1:0]                      stall_waw,
    input  logic [NUM_WARPS-1:0]                      stall_war,
    input  logic [NUM_WARPS-1:0]                      stall_busy,
    output logic                                      finished,
    output logic [COUNTER_WIDTH-1:0]                  instRetired,
    output logic [COUNTER_WIDTH-1:0]                  cycles,
    output logic [COUNTER_WIDTH-1:0]                  cyclesDecoded,
    output logic [COUNTER_WIDTH-1:0]                  cyclesEligible,
    output logic [COUNTER_WIDTH-1:0]                  cyclesIssued,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]        perWarp_cyclesDecoded,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]        perWarp_cyclesIssued,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]        perWarp_stallsWAW,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]        perWarp_stallsWAR,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]        perWarp_stallsBusy
);

    localparam int RC_W     = retire_count_width(RETIRE_WIDTH);
    // Never narrower than the default build's drain counter.
    localparam int DRAIN_W  = (drain_count_width(DRAIN_CYCLES) > DRAIN_COUNT_W)
                              ? drain_count_width(DRAIN_CYCLES) : DRAIN_COUNT_W;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    perf_state_t        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               idle_in;
    logic               count_en;
    logic               frozen;

    // A cycle is idle when no warp is live and nothing retires.
    assign idle_in  = (warp_active == '0) && (retire_count == '0);
    // Counting starts on the first active cycle and stops once DONE.
    assign count_en = (state_q == RUN) || (state_q == DRAIN) ||
                      ((state_q == IDLE) && (|warp_active));
    assign frozen   = (state_q == DONE);

    // Next-state and drain-count logic; the RUN->DRAIN cycle is idle cycle 1.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (|warp_active) state_d = RUN;
            end
            RUN: begin
                if (idle_in) begin
                    if (DRAIN_CYCLES <= 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!idle_in) begin
                    state_d = RUN;
                    drain_d = '0;
                end else if (drain_q >= DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                drain_d = '0;
            end
        endcase
    end

    // State register; `finished` rises together with DONE entry and sticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            finished <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            finished <= (state_d == DONE);
        end
    end

    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(RC_W)) u_inst_retired (
        .clock(clock), .reset(reset), .enable(count_en), .amount(retire_count),
        .freeze(frozen), .count(instRetired));

    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles (
        .clock(clock), .reset(reset), .enable(count_en), .amount(1'b1),
        .freeze(frozen), .count(cycles));

    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles_decoded (
        .clock(clock), .reset(reset), .enable(count_en && (|decode_valid)), .amount(1'b1),
        .freeze(frozen), .count(cyclesDecoded));

    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles_eligible (
        .clock(clock), .reset(reset), .enable(count_en && (|eligible_valid)), .amount(1'b1),
        .freeze(frozen), .count(cyclesEligible));

    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles_issued (
        .clock(clock), .reset(reset), .enable(count_en && (|issue_fire)), .amount(1'b1),
        .freeze(frozen), .count(cyclesIssued));

    // Per-warp counters; a stall only counts while the head is decoded and not issuing.
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_decoded (
            .clock(clock), .reset(reset), .enable(count_en && decode_valid[w]), .amount(1'b1),
            .freeze(frozen), .count(perWarp_cyclesDecoded[w*COUNTER_WIDTH +: COUNTER_WIDTH]));

        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_issued (
            .clock(clock), .reset(reset), .enable(count_en && issue_fire[w]), .amount(1'b1),
            .freeze(frozen), .count(perWarp_cyclesIssued[w*COUNTER_WIDTH +: COUNTER_WIDTH]));

        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_stall_waw (
            .clock(clock), .reset(reset),
            .enable(count_en && decode_valid[w] && stall_waw[w] && !issue_fire[w]), .amount(1'b1),
            .freeze(frozen), .count(perWarp_stallsWAW[w*COUNTER_WIDTH +: COUNTER_WIDTH]));

        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_stall_war (
            .clock(clock), .reset(reset),
            .enable(count_en && decode_valid[w] && stall_war[w] && !issue_fire[w]), .amount(1'b1),
            .freeze(frozen), .count(perWarp_stallsWAR[w*COUNTER_WIDTH +: COUNTER_WIDTH]));

        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_stall_busy (
            .clock(clock), .reset(reset),
            .enable(count_en && decode_valid[w] && stall_busy[w] && !issue_fire[w]), .amount(1'b1),
            .freeze(frozen), .count(perWarp_stallsBusy[w*COUNTER_WIDTH +: COUNTER_WIDTH]));
    end

`ifndef SYNTHESIS
    localparam logic [RC_W-1:0] RETIRE_MAX = RC_W'(RETIRE_WIDTH);

    // Input legality: the scheduler never violates these; the counters still add raw values.
    a_retire_range : assert property (@(posedge clock) disable iff (reset)
        retire_count <= RETIRE_MAX);
    a_issue_onehot : assert property (@(posedge clock) disable iff (reset)
        $onehot0(issue_fire));
    a_issue_decoded : assert property (@(posedge clock) disable iff (reset)
        (issue_fire & ~decode_valid) == '0);
`endif

endmodule

// File: tb/tb_core_perf_counters.sv
// tb_core_perf_counters: scoreboard bench for core_perf_counters. Two DUTs
// share stimulus: a 16-bit-counter build and a 4-bit-counter build (wrap or
// saturate, following PERF_COUNTER_SATURATE_EN). The reference model keeps
// exact event totals and a simple idle streak; expected outputs are derived
// from those totals by modulo or clamping to each build's width.
module tb_core_perf_counters;

    localparam int NW  = 8;
    localparam int CW  = 16;
    localparam int CWS = 4;
    localparam int RW  = 4;
    localparam int DC  = 4;
    localparam int RCW = 3;

    typedef struct packed {
        logic                 fin;
        logic [63:0]          cyc, ret, cd, ce, ci;
        logic [NW-1:0][63:0]  pd, pi, waw, war, busy;
    } snap_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NW-1:0] warp_active = '0, decode_valid = '0, eligible_valid = '0, issue_fire = '0;
    logic [NW-1:0] stall_waw = '0, stall_war = '0, stall_busy = '0;
    logic [RCW-1:0] retire_count = '0;

    logic              fin_a;
    logic [CW-1:0]     ret_a, cyc_a, cd_a, ce_a, ci_a;
    logic [NW*CW-1:0]  pd_a, pi_a, waw_a, war_a, busy_a;
    logic              fin_b;
    logic [CWS-1:0]    ret_b, cyc_b, cd_b, ce_b, ci_b;
    logic [NW*CWS-1:0] pd_b, pi_b, waw_b, war_b, busy_b;

    int checks = 0;
    int errors = 0;

    snap_t m;
    snap_t exp_s;
    snap_t sb_q[$];
    logic  started = 1'b0;
    logic  done = 1'b0;
    int    streak = 0;

    always #5 clock = ~clock;

    core_perf_counters #(.NUM_WARPS(NW), .COUNTER_WIDTH(CW), .RETIRE_WIDTH(RW), .DRAIN_CYCLES(DC)) u_dut_a (
        .clock(clock), .reset(reset), .warp_active(warp_active), .retire_count(retire_count),
        .decode_valid(decode_valid), .eligible_valid(eligible_valid), .issue_fire(issue_fire),
        .stall_waw(stall_waw), .stall_war(stall_war), .stall_busy(stall_busy),
        .finished(fin_a), .instRetired(ret_a), .cycles(cyc_a), .cyclesDecoded(cd_a),
        .cyclesEligible(ce_a), .cyclesIssued(ci_a), .perWarp_cyclesDecoded(pd_a),
        .perWarp_cyclesIssued(pi_a), .perWarp_stallsWAW(waw_a), .perWarp_stallsWAR(war_a),
        .perWarp_stallsBusy(busy_a));

    core_perf_counters #(.NUM_WARPS(NW), .COUNTER_WIDTH(CWS), .RETIRE_WIDTH(RW), .DRAIN_CYCLES(DC)) u_dut_b (
        .clock(clock), .reset(reset), .warp_active(warp_active), .retire_count(retire_count),
        .decode_valid(decode_valid), .eligible_valid(eligible_valid), .issue_fire(issue_fire),
        .stall_waw(stall_waw), .stall_war(stall_war), .stall_busy(stall_busy),
        .finished(fin_b), .instRetired(ret_b), .cycles(cyc_b), .cyclesDecoded(cd_b),
        .cyclesEligible(ce_b), .cyclesIssued(ci_b), .perWarp_cyclesDecoded(pd_b),
        .perWarp_cyclesIssued(pi_b), .perWarp_stallsWAW(waw_b), .perWarp_stallsWAR(war_b),
        .perWarp_stallsBusy(busy_b));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Exact total reduced to a w-bit counter: modulo, or clamped when saturating.
    function automatic logic [63:0] fit(input logic [63:0] v, input int w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
`ifdef PERF_COUNTER_SATURATE_EN
        return (v > mx) ? mx : v;
`else
        return v & mx;
`endif
    endfunction

    // Drive one cycle of inputs, advance the reference model, queue the expectation.
    task automatic step(input logic rst, input logic [NW-1:0] act, input logic [RCW-1:0] rc,
                        input logic [NW-1:0] dv, input logic [NW-1:0] ev, input logic [NW-1:0] iss,
                        input logic [NW-1:0] sw, input logic [NW-1:0] sr, input logic [NW-1:0] sb);
        @(negedge clock);
        reset = rst; warp_active = act; retire_count = rc; decode_valid = dv;
        eligible_valid = ev; issue_fire = iss; stall_waw = sw; stall_war = sr; stall_busy = sb;
        if (rst) begin
            m = '0; started = 1'b0; done = 1'b0; streak = 0;
        end else if (!done && (started || act != '0)) begin
            m.cyc += 64'd1;
            m.ret += 64'(rc);
            m.cd  += 64'(|dv);
            m.ce  += 64'(|ev);
            m.ci  += 64'(|iss);
            for (int w = 0; w < NW; w++) begin
                m.pd[w]   += 64'(dv[w]);
                m.pi[w]   += 64'(iss[w]);
                m.waw[w]  += 64'(dv[w] & sw[w] & ~iss[w]);
                m.war[w]  += 64'(dv[w] & sr[w] & ~iss[w]);
                m.busy[w] += 64'(dv[w] & sb[w] & ~iss[w]);
            end
            started = 1'b1;
            if (act == '0 && rc == '0) streak++;
            else streak = 0;
            if (streak >= DC) done = 1'b1;
        end
        m.fin = done;
        sb_q.push_back(m);
    endtask

    task automatic run(input int n, input logic [NW-1:0] act, input logic [RCW-1:0] rc);
        for (int i = 0; i < n; i++) step(1'b0, act, rc, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    // Let the last driven cycle land, then sample well after the edge.
    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Monitor: every cycle with a queued expectation, compare both DUTs.
    always @(posedge clock) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_s = sb_q.pop_front();
            check("A.finished", 64'(fin_a), 64'(exp_s.fin));
            check("A.cycles", 64'(cyc_a), fit(exp_s.cyc, CW));
            check("A.instRetired", 64'(ret_a), fit(exp_s.ret, CW));
            check("A.cyclesDecoded", 64'(cd_a), fit(exp_s.cd, CW));
            check("A.cyclesEligible", 64'(ce_a), fit(exp_s.ce, CW));
            check("A.cyclesIssued", 64'(ci_a), fit(exp_s.ci, CW));
            check("B.finished", 64'(fin_b), 64'(exp_s.fin));
            check("B.cycles", 64'(cyc_b), fit(exp_s.cyc, CWS));
            check("B.instRetired", 64'(ret_b), fit(exp_s.ret, CWS));
            check("B.cyclesDecoded", 64'(cd_b), fit(exp_s.cd, CWS));
            check("B.cyclesEligible", 64'(ce_b), fit(exp_s.ce, CWS));
            check("B.cyclesIssued", 64'(ci_b), fit(exp_s.ci, CWS));
            for (int w = 0; w < NW; w++) begin
                check($sformatf("A.pwDecoded[%0d]", w), 64'(pd_a[w*CW +: CW]), fit(exp_s.pd[w], CW));
                check($sformatf("A.pwIssued[%0d]", w), 64'(pi_a[w*CW +: CW]), fit(exp_s.pi[w], CW));
                check($sformatf("A.pwWAW[%0d]", w), 64'(waw_a[w*CW +: CW]), fit(exp_s.waw[w], CW));
                check($sformatf("A.pwWAR[%0d]", w), 64'(war_a[w*CW +: CW]), fit(exp_s.war[w], CW));
                check($sformatf("A.pwBusy[%0d]", w), 64'(busy_a[w*CW +: CW]), fit(exp_s.busy[w], CW));
                check($sformatf("B.pwDecoded[%0d]", w), 64'(pd_b[w*CWS +: CWS]), fit(exp_s.pd[w], CWS));
                check($sformatf("B.pwIssued[%0d]", w), 64'(pi_b[w*CWS +: CWS]), fit(exp_s.pi[w], CWS));
                check($sformatf("B.pwWAW[%0d]", w), 64'(waw_b[w*CWS +: CWS]), fit(exp_s.waw[w], CWS));
                check($sformatf("B.pwWAR[%0d]", w), 64'(war_b[w*CWS +: CWS]), fit(exp_s.war[w], CWS));
                check($sformatf("B.pwBusy[%0d]", w), 64'(busy_b[w*CWS +: CWS]), fit(exp_s.busy[w], CWS));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [NW-1:0]  act, dv, ev, iss, sw, sr, sb;
        logic [RCW-1:0] rc;
        logic           quiet;
        int             wsel;

        // Basic run: 10 active cycles, then 4 drain cycles -> finished, cycles=14.
        do_reset();
        run(10, 8'h01, 3'd0);
        run(4, 8'h00, 3'd0);
        settle();
        check("basic.finished", 64'(fin_a), 64'd1);
        check("basic.cycles", 64'(cyc_a), 64'd14);
        run(5, 8'h01, 3'd2);
        settle();
        check("basic.frozen_cycles", 64'(cyc_a), 64'd14);
        check("basic.frozen_retired", 64'(ret_a), 64'd0);

        // Retire accumulation: 5x3 + 2x4 = 23.
        do_reset();
        run(5, 8'h01, 3'd3);
        run(2, 8'h01, 3'd4);
        settle();
        check("retire.instRetired", 64'(ret_a), 64'd23);

        // Per-warp stalls: warp 2 blocked by WAW and busy, warp 0 issues every cycle.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b0, 8'h05, 3'd0, 8'h05, 8'h00, 8'h01, 8'h04, 8'h00, 8'h05);
        settle();
        check("stall.waw2", 64'(waw_a[2*CW +: CW]), 64'd10);
        check("stall.busy2", 64'(busy_a[2*CW +: CW]), 64'd10);
        check("stall.busy0", 64'(busy_a[0*CW +: CW]), 64'd0);
        check("stall.issued0", 64'(pi_a[0*CW +: CW]), 64'd10);
        check("stall.cyclesIssued", 64'(ci_a), 64'd10);
        check("stall.cyclesDecoded", 64'(cd_a), 64'd10);

        // Drain abort: 3 idle, 1 active, then 4 fresh idle cycles needed.
        do_reset();
        run(2, 8'h01, 3'd0);
        run(3, 8'h00, 3'd0);
        run(1, 8'h02, 3'd0);
        run(3, 8'h00, 3'd0);
        settle();
        check("abort.not_finished", 64'(fin_a), 64'd0);
        run(1, 8'h00, 3'd0);
        settle();
        check("abort.finished", 64'(fin_a), 64'd1);
        check("abort.cycles", 64'(cyc_a), 64'd10);

        // Overflow on the 4-bit build: 6x3 = 18 -> 2 wrapped, 15 saturated.
        do_reset();
        run(6, 8'h01, 3'd3);
        settle();
`ifdef PERF_COUNTER_SATURATE_EN
        check("overflow.instRetired_b", 64'(ret_b), 64'd15);
`else
        check("overflow.instRetired_b", 64'(ret_b), 64'd2);
`endif
        check("overflow.instRetired_a", 64'(ret_a), 64'd18);

        // Reset mid-DRAIN, then an idle core (retire alone does not start counting).
        do_reset();
        run(3, 8'h01, 3'd1);
        run(2, 8'h00, 3'd0);
        do_reset();
        settle();
        check("midreset.finished", 64'(fin_a), 64'd0);
        check("midreset.cycles", 64'(cyc_a), 64'd0);
        check("midreset.instRetired", 64'(ret_a), 64'd0);
        run(5, 8'h00, 3'd2);
        settle();
        check("idle.cycles", 64'(cyc_a), 64'd0);
        check("idle.instRetired", 64'(ret_a), 64'd0);
        check("idle.finished", 64'(fin_a), 64'd0);

        // Randomized episodes alternating busy and quiet stretches.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            quiet = 1'b0;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 9) == 0) quiet = ~quiet;
                if (quiet) begin
                    act = '0; rc = '0; dv = '0; ev = '0; iss = '0; sw = '0; sr = '0; sb = '0;
                    if ($urandom_range(0, 7) == 0) rc = RCW'($urandom_range(1, RW));
                end else begin
                    act = NW'($urandom);
                    rc  = RCW'($urandom_range(0, RW));
                    dv  = NW'($urandom);
                    ev  = NW'($urandom);
                    sw  = NW'($urandom);
                    sr  = NW'($urandom);
                    sb  = NW'($urandom);
                    iss = '0;
                    wsel = $urandom_range(0, NW - 1);
                    if (dv[wsel] && $urandom_range(0, 1) == 1) iss[wsel] = 1'b1;
                end
                step(($urandom_range(0, 149) == 0), act, rc, dv, ev, iss, sw, sr, sb);
            end
        end

        settle();
        repeat (2) @(posedge clock);
        #3;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
